// File: rtl/msx_bank_mapper_if.sv
// Slot-side bus and memory-side strobes of the MSX bank mapper.
// The slave modport is the mapper's view; master is the slot/bus driver's view.
interface msx_bank_mapper_if #(
    parameter int BANK_BITS = 6
);
    logic                 SLT_SLTSL;
    logic                 SLT_WEn;
    logic                 SLT_RDn;
    logic [15:0]          SLT_A;
    logic [7:0]           SLT_D;
    logic                 SW_ROMenable;
    logic [BANK_BITS-1:0] ROM_BA;
    logic                 ROM_CEn;
    logic                 ROM_OEn;
    logic                 ROM_WEn;
    logic                 RAM_CEn;
    logic                 FLASH_BUSY;
    logic                 BANK_PENDING;

    modport slave (
        input  SLT_SLTSL, SLT_WEn, SLT_RDn, SLT_A, SLT_D, SW_ROMenable,
        output ROM_BA, ROM_CEn, ROM_OEn, ROM_WEn, RAM_CEn, FLASH_BUSY, BANK_PENDING
    );

    modport master (
        output SLT_SLTSL, SLT_WEn, SLT_RDn, SLT_A, SLT_D, SW_ROMenable,
        input  ROM_BA, ROM_CEn, ROM_OEn, ROM_WEn, RAM_CEn, FLASH_BUSY, BANK_PENDING
    );
endinterface

// File: rtl/msx_bank_mapper.sv
// Parametrised 8 KB-page MSX cartridge bank mapper with delayed commit and RAM window.
// Optional Flash program-command tracker with bank-write deferral: FLASH_CMD_TRACK_EN.

// One bank register: commit pipeline of STAGES extra cycles plus optional pending slot.
module msx_bank_slot #(
    parameter int                   BANK_BITS = 6,
    parameter int                   STAGES    = 0,
    parameter logic [BANK_BITS-1:0] RESET_VAL = '0
) (
    input  logic                 SLT_CLOCK,
    input  logic                 SLT_RESET,
    input  logic                 wr_en,
    input  logic [BANK_BITS-1:0] wr_data,
`ifdef FLASH_CMD_TRACK_EN
    input  logic                 defer,
    output logic                 pend_full,
`endif
    output logic [BANK_BITS-1:0] bank_q
);
    logic [STAGES:0]                vld_pipe;
    logic [STAGES:0][BANK_BITS-1:0] dat_pipe;
    logic [BANK_BITS-1:0]           bank_r;
    logic                           in_vld;
    logic [BANK_BITS-1:0]           in_data;

`ifdef FLASH_CMD_TRACK_EN
    logic [BANK_BITS-1:0] pend_val;
    logic                 direct;
    logic                 flush;

    // A direct write in the flush cycle is the later write, so it wins.
    assign direct  = wr_en & ~defer;
    assign flush   = pend_full & ~defer;
    assign in_vld  = direct | flush;
    assign in_data = direct ? wr_data : pend_val;

    always_ff @(posedge SLT_CLOCK) begin
        if (SLT_RESET) begin
            pend_full <= 1'b0;
            pend_val  <= '0;
        end else if (wr_en && defer) begin
            pend_full <= 1'b1;
            pend_val  <= wr_data;
        end else if (flush) begin
            pend_full <= 1'b0;
        end
    end
`else
    assign in_vld  = wr_en;
    assign in_data = wr_data;
`endif

    // Last stage bypasses into the visible value so latency is 1+STAGES.
    assign bank_q = vld_pipe[STAGES] ? dat_pipe[STAGES] : bank_r;

    always_ff @(posedge SLT_CLOCK) begin
        if (SLT_RESET) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
            bank_r   <= RESET_VAL;
        end else begin
            vld_pipe[0] <= in_vld;
            dat_pipe[0] <= in_data;
            for (int s = 1; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                dat_pipe[s] <= dat_pipe[s-1];
            end
            bank_r <= bank_q;
        end
    end
endmodule

module msx_bank_mapper #(
    parameter int         NUM_BANKS    = 4,
    parameter int         BANK_BITS    = 6,
    parameter bit         FIXED_BANK0  = 1'b1,
    parameter logic [5:0] DELAY_MASK   = 6'b000010,
    parameter int         COMMIT_DELAY = 1,
    parameter int         RAM_BIT      = 4,
    parameter int         PROG_CYCLES  = 8
) (
    input logic              SLT_CLOCK,
    input logic              SLT_RESET,
    msx_bank_mapper_if.slave bus
);
    logic                                sel;
    logic                                wr;
    logic                                wr_q;
    logic                                wr_pulse;
    logic                                ctl_wr;
    logic                                fwm;
    logic [3:0]                          win_idx;
    logic                                in_window;
    logic                                last_win;
    logic                                ram_mode;
    logic                                busy;
    logic [NUM_BANKS-1:0]                pend;
    logic [NUM_BANKS-1:0][BANK_BITS-1:0] bank;
    logic [BANK_BITS-1:0]                cur_bank;
    logic [BANK_BITS-1:0]                rom_ba;
    logic                                unused_bits;

    assign sel      = ~bus.SLT_SLTSL & bus.SW_ROMenable;
    assign wr       = sel & ~bus.SLT_WEn;
    assign wr_pulse = wr & ~wr_q;

    // Addresses below 4000h wrap to 14/15 and fall outside every window.
    assign win_idx   = {1'b0, bus.SLT_A[15:13]} - 4'd2;
    assign in_window = win_idx < 4'(NUM_BANKS);
    assign last_win  = win_idx == 4'(NUM_BANKS - 1);
    assign ctl_wr    = wr_pulse & in_window & ~bus.SLT_A[12];

    always_ff @(posedge SLT_CLOCK) begin
        if (SLT_RESET) begin
            wr_q <= 1'b0;
            fwm  <= 1'b0;
        end else begin
            wr_q <= wr;
            if (ctl_wr && last_win)
                fwm <= bus.SLT_D[7];
        end
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        if (FIXED_BANK0 && i == 0) begin : g_fixed
            assign bank[i] = '0;
            assign pend[i] = 1'b0;
        end else begin : g_slot
            logic slot_pend;
            msx_bank_slot #(
                .BANK_BITS (BANK_BITS),
                .STAGES    (DELAY_MASK[i] ? COMMIT_DELAY : 0),
                .RESET_VAL (BANK_BITS'(i))
            ) u_slot (
                .SLT_CLOCK (SLT_CLOCK),
                .SLT_RESET (SLT_RESET),
                .wr_en     (ctl_wr && win_idx == 4'(i)),
                .wr_data   (bus.SLT_D[BANK_BITS-1:0]),
`ifdef FLASH_CMD_TRACK_EN
                .defer     (busy),
                .pend_full (slot_pend),
`endif
                .bank_q    (bank[i])
            );
`ifndef FLASH_CMD_TRACK_EN
            assign slot_pend = 1'b0;
`endif
            assign pend[i] = slot_pend;
        end
    end

`ifdef FLASH_CMD_TRACK_EN
    typedef enum logic [2:0] {ST_IDLE, ST_U1, ST_U2, ST_PROG, ST_BUSY} trk_state_t;
    trk_state_t state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       is_aa, is_55, is_a0, is_f0;

    assign is_aa = bus.SLT_A == 16'h5555 && bus.SLT_D == 8'hAA;
    assign is_55 = bus.SLT_A == 16'h4AAA && bus.SLT_D == 8'h55;
    assign is_a0 = bus.SLT_A == 16'h5555 && bus.SLT_D == 8'hA0;
    assign is_f0 = bus.SLT_D == 8'hF0;

    always_ff @(posedge SLT_CLOCK) begin
        if (SLT_RESET) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == ST_BUSY) begin
            if (cnt == 8'd0) state_nxt = ST_IDLE;
            else             cnt_nxt   = cnt - 8'd1;
        end
        if (wr_pulse) begin
            case (state)
                ST_IDLE: state_nxt = is_aa ? ST_U1 : ST_IDLE;
                ST_U1:   state_nxt = is_55 ? ST_U2 : (is_aa ? ST_U1 : ST_IDLE);
                ST_U2:   state_nxt = is_a0 ? ST_PROG : (is_aa ? ST_U1 : ST_IDLE);
                ST_PROG: begin
                    state_nxt = ST_BUSY;
                    cnt_nxt   = 8'(PROG_CYCLES - 1);
                end
                default: ;
            endcase
            if (is_f0) state_nxt = ST_IDLE;
        end
        if (!fwm) state_nxt = ST_IDLE;
    end

    assign busy             = state == ST_BUSY;
    assign bus.FLASH_BUSY   = busy;
    assign bus.BANK_PENDING = |pend;
`else
    assign busy             = 1'b0;
    assign bus.FLASH_BUSY   = 1'b0;
    assign bus.BANK_PENDING = 1'b0;
`endif

    always_comb begin
        cur_bank = '0;
        for (int i = 0; i < NUM_BANKS; i++)
            if (win_idx == 4'(i)) cur_bank = bank[i];
    end

    assign ram_mode = last_win & bank[NUM_BANKS-1][RAM_BIT];

    always_comb begin
        rom_ba = '0;
        if (ram_mode)
            rom_ba = BANK_BITS'(bank[NUM_BANKS-1][RAM_BIT+1]);
        else if (in_window && win_idx == 4'd0 && fwm)
            rom_ba = bus.SLT_A[12] ? BANK_BITS'(2) : BANK_BITS'(1);
        else if (in_window)
            rom_ba = cur_bank;
    end

    assign bus.ROM_BA  = rom_ba;
    assign bus.ROM_CEn = ram_mode | ~(sel & in_window);
    assign bus.RAM_CEn = ram_mode ? ~(sel & bus.SLT_A[12]) : 1'b1;
    assign bus.ROM_OEn = bus.SLT_RDn | ~in_window;
    assign bus.ROM_WEn = bus.SLT_WEn;

    // Low address/data bits only matter to the tracker or wider registers.
    assign unused_bits = ^{bus.SLT_A[11:0], bus.SLT_D, busy, 8'(PROG_CYCLES)};
endmodule

// File: tb/tb_msx_bank_mapper.sv
// Directed bench for msx_bank_mapper; tracker steps compile in with FLASH_CMD_TRACK_EN.
module tb_msx_bank_mapper;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    msx_bank_mapper_if #(.BANK_BITS(6)) bus ();

    msx_bank_mapper #(
        .NUM_BANKS(4), .BANK_BITS(6), .FIXED_BANK0(1'b1), .DELAY_MASK(6'b000010),
        .COMMIT_DELAY(1), .RAM_BIT(4), .PROG_CYCLES(8)
    ) dut (
        .SLT_CLOCK (clk),
        .SLT_RESET (rst),
        .bus       (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic look(input logic [15:0] a);
        bus.SLT_A = a;
        #1;
    endtask

    // One-cycle write strobe; returns one cycle after the pulse cycle.
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        tick();
        bus.SLT_A = a; bus.SLT_D = d; bus.SLT_SLTSL = 1'b0; bus.SLT_WEn = 1'b0;
        tick();
        bus.SLT_SLTSL = 1'b1; bus.SLT_WEn = 1'b1;
    endtask

    task automatic prog_seq(input logic [15:0] a, input logic [7:0] d);
        wr(16'h5555, 8'hAA);
        wr(16'h4AAA, 8'h55);
        wr(16'h5555, 8'hA0);
        wr(a, d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.SLT_SLTSL = 1'b1; bus.SLT_WEn = 1'b1; bus.SLT_RDn = 1'b1;
        bus.SLT_A = 16'h0000; bus.SLT_D = 8'h00; bus.SW_ROMenable = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        look(16'h6000); chk("rst_ba_w1", 16'(bus.ROM_BA), 16'h1);
        look(16'h8000); chk("rst_ba_w2", 16'(bus.ROM_BA), 16'h2);
        look(16'hA000); chk("rst_ba_w3", 16'(bus.ROM_BA), 16'h3);
        look(16'h4000); chk("rst_ba_w0", 16'(bus.ROM_BA), 16'h0);
        chk("rst_busy", 16'(bus.FLASH_BUSY), 16'h0);
        chk("rst_pend", 16'(bus.BANK_PENDING), 16'h0);
        tick();
        bus.SLT_SLTSL = 1'b0; bus.SLT_RDn = 1'b0;
        look(16'h6000);
        chk("rd_cen", 16'(bus.ROM_CEn), 16'h0);
        chk("rd_oen", 16'(bus.ROM_OEn), 16'h0);
        chk("rd_ramcen", 16'(bus.RAM_CEn), 16'h1);
        look(16'h2000);
        chk("out_cen", 16'(bus.ROM_CEn), 16'h1);
        chk("out_oen", 16'(bus.ROM_OEn), 16'h1);
        chk("out_ba", 16'(bus.ROM_BA), 16'h0);
        tick();
        bus.SW_ROMenable = 1'b0;
        look(16'h6000); chk("swoff_cen", 16'(bus.ROM_CEn), 16'h1);
        bus.SW_ROMenable = 1'b1; bus.SLT_SLTSL = 1'b1; bus.SLT_RDn = 1'b1;

        // Masked bank 1: visible two cycles after the pulse
        wr(16'h6000, 8'h05);
        look(16'h6000); chk("w1_dly_p1", 16'(bus.ROM_BA), 16'h1);
        tick();         chk("w1_dly_p2", 16'(bus.ROM_BA), 16'h5);

        // Unmasked bank 2: visible one cycle after the pulse
        wr(16'h8000, 8'h2A);
        look(16'h8000); chk("w2_nodly", 16'(bus.ROM_BA), 16'h2A);

        // Held-low write counts once: the data change mid-strobe is ignored
        tick();
        bus.SLT_A = 16'h8000; bus.SLT_D = 8'h11; bus.SLT_SLTSL = 1'b0; bus.SLT_WEn = 1'b0;
        tick(); bus.SLT_D = 8'h22;
        tick(); bus.SLT_D = 8'h33;
        tick(); bus.SLT_SLTSL = 1'b1; bus.SLT_WEn = 1'b1;
        tick(); look(16'h8000); chk("held_we", 16'(bus.ROM_BA), 16'h11);

        // RAM window
        wr(16'hA000, 8'h10);
        bus.SLT_SLTSL = 1'b0; bus.SLT_RDn = 1'b0;
        look(16'hB000);
        chk("ram_ramcen", 16'(bus.RAM_CEn), 16'h0);
        chk("ram_romcen", 16'(bus.ROM_CEn), 16'h1);
        chk("ram_ba0", 16'(bus.ROM_BA), 16'h0);
        bus.SLT_SLTSL = 1'b1; bus.SLT_RDn = 1'b1;
        wr(16'hA000, 8'h30);
        bus.SLT_SLTSL = 1'b0; bus.SLT_RDn = 1'b0;
        look(16'hB000); chk("ram_ba1", 16'(bus.ROM_BA), 16'h1);
        look(16'hA000); chk("ram_lo_ramcen", 16'(bus.RAM_CEn), 16'h1);
        bus.SLT_SLTSL = 1'b1; bus.SLT_RDn = 1'b1;

        // Flash write mode on: window 0 splits into pages 1/2
        wr(16'hA000, 8'h80);
        look(16'h4AAA); chk("fwm_4aaa", 16'(bus.ROM_BA), 16'h1);
        look(16'h5555); chk("fwm_5555", 16'(bus.ROM_BA), 16'h2);
        bus.SLT_SLTSL = 1'b0;
        look(16'hB000);
        chk("fwm_w3_ramcen", 16'(bus.RAM_CEn), 16'h1);
        chk("fwm_w3_ba", 16'(bus.ROM_BA), 16'h0);
        bus.SLT_SLTSL = 1'b1;

`ifdef FLASH_CMD_TRACK_EN
        // Program sequence; the data write also loads bank 2
        prog_seq(16'h8000, 8'h3C);                              // now cycle P+1
        look(16'h8000);
        chk("busy_rise", 16'(bus.FLASH_BUSY), 16'h1);
        chk("busy_prog_bank", 16'(bus.ROM_BA), 16'h3C);
        wr(16'h8000, 8'h07);                                    // pulse P+2
        wr(16'h8000, 8'h09);                                    // pulse P+4, now P+5
        look(16'h8000);
        chk("pend_set", 16'(bus.BANK_PENDING), 16'h1);
        chk("pend_ba_old", 16'(bus.ROM_BA), 16'h3C);
        tick(); tick(); tick();                                 // P+8
        chk("busy_last", 16'(bus.FLASH_BUSY), 16'h1);
        tick();                                                 // P+9
        chk("busy_fall", 16'(bus.FLASH_BUSY), 16'h0);
        chk("flush_ba_old", 16'(bus.ROM_BA), 16'h3C);
        chk("flush_pend_old", 16'(bus.BANK_PENDING), 16'h1);
        tick();                                                 // P+10
        chk("flush_ba", 16'(bus.ROM_BA), 16'h9);
        chk("flush_pend", 16'(bus.BANK_PENDING), 16'h0);

        // Broken unlock returns to IDLE; a later 55h does not resume it
        wr(16'h5555, 8'hAA);
        wr(16'h4AAA, 8'h12);
        wr(16'h4AAA, 8'h55);
        wr(16'h5555, 8'hA0);
        wr(16'h5555, 8'h3C);
        chk("abort_idle", 16'(bus.FLASH_BUSY), 16'h0);

        // F0h aborts BUSY
        prog_seq(16'h5555, 8'h3C);
        chk("f0_busy_before", 16'(bus.FLASH_BUSY), 16'h1);
        wr(16'h5555, 8'hF0);
        chk("f0_busy_after", 16'(bus.FLASH_BUSY), 16'h0);

        // Enter BUSY with a pending write ahead of the reset test
        prog_seq(16'h5555, 8'h3C);
        wr(16'h8000, 8'h15);
        look(16'h8000);
        chk("rstb_pend", 16'(bus.BANK_PENDING), 16'h1);
        chk("rstb_ba", 16'(bus.ROM_BA), 16'h9);
`else
        // Without the tracker nothing is ever deferred
        prog_seq(16'h8000, 8'h3C);
        look(16'h8000);
        chk("nt_busy", 16'(bus.FLASH_BUSY), 16'h0);
        chk("nt_prog_bank", 16'(bus.ROM_BA), 16'h3C);
        wr(16'h8000, 8'h07);
        look(16'h8000);
        chk("nt_direct", 16'(bus.ROM_BA), 16'h7);
        chk("nt_pend", 16'(bus.BANK_PENDING), 16'h0);
`endif

        // Reset with a simultaneous write: reset wins, nothing commits
        rst = 1'b1;
        bus.SLT_A = 16'h6000; bus.SLT_D = 8'h3F; bus.SLT_SLTSL = 1'b0; bus.SLT_WEn = 1'b0;
        tick();
        bus.SLT_SLTSL = 1'b1; bus.SLT_WEn = 1'b1;
        look(16'h8000); chk("rst2_w2", 16'(bus.ROM_BA), 16'h2);
        look(16'h6000); chk("rst2_w1", 16'(bus.ROM_BA), 16'h1);
        chk("rst2_busy", 16'(bus.FLASH_BUSY), 16'h0);
        chk("rst2_pend", 16'(bus.BANK_PENDING), 16'h0);
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        look(16'h8000); chk("post_w2", 16'(bus.ROM_BA), 16'h2);
        look(16'h6000); chk("post_w1", 16'(bus.ROM_BA), 16'h1);
        look(16'h4AAA); chk("post_fwm", 16'(bus.ROM_BA), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
